// File: rtl/multi_clken_pkg.sv
// multi_clken_pkg
//   Shared types and width helpers for the multi-channel clock-enable
//   generator: FSM state encoding, channel-select width and the width of
//   the lock settle counter.
package multi_clken_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      LOCKED = 2'd1,
      APPLY  = 2'd2
   } state_e;

   // Channel select width; at least one bit even for a single channel.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Settle counter must hold LOCK_CYCLES-1.
   function automatic int settle_width(input int l);
      return (l <= 1) ? 1 : $clog2(l + 1);
   endfunction

endpackage

// File: rtl/clken_ch.sv
// clken_ch
//   One output channel: divide/phase registers, a wrap counter that runs
//   0..div-1, and the combinational clken/clksq decode.
// Ports:
//   refclk_i, rst_i  clock and async active-high reset
//   clr_i            synchronous counter clear (global re-alignment)
//   load_i           write div_i/phase_i into this channel
//   div_i, phase_i   new divide ratio (0 = off) and already-clamped phase
//   locked_i, en_i   global lock and per-channel live gate
//   clken_o          one-cycle strobe when cnt == phase
//   clksq_o          high for the first ceil(div/2) counts of each period
module clken_ch #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             refclk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [DIV_W-1:0] phase_i,
   input  logic             locked_i,
   input  logic             en_i,
   output logic             clken_o,
   output logic             clksq_o
);

   logic [DIV_W-1:0] div_q, phase_q;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W:0]   half;
   logic             active;

   // div == 0 parks the counter at 0; the div_q check guards div_q-1 underflow.
   always_comb begin
      cnt_d = cnt_q + DIV_W'(1);
      if (clr_i || (div_q == '0) || (cnt_q >= div_q - DIV_W'(1)))
         cnt_d = '0;
   end

   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q   <= DIV_W'(DEFAULT_DIV);
         phase_q <= '0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_i) begin
            div_q   <= div_i;
            phase_q <= phase_i;
         end
      end
   end

   // One extra bit so div = 2^DIV_W-1 rounds up without overflow.
   assign half    = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
   assign active  = locked_i & en_i & (div_q != '0);
   assign clken_o = active & (cnt_q == phase_q);
   assign clksq_o = active & ({1'b0, cnt_q} < half);

endmodule

// File: rtl/multi_clken_gen.sv
// multi_clken_gen
//   NUM_CH programmable clock-enable generators in the refclk domain.
//   A valid/ready request latches a channel configuration; the following
//   APPLY cycle writes it, clears every channel counter together and
//   restarts a LOCK_CYCLES settle window, after which locked rises.
// Ports:
//   refclk, rst            clock and async active-high reset
//   cfg_valid/cfg_ready    reconfiguration handshake
//   cfg_ch/div/phase       target channel, divide ratio (0=off), phase
//   cfg_err                one-cycle pulse: phase clamped or bad channel
//   ch_enable              live per-channel output gate
//   clken_out, clksq_out   per-channel strobe and square-wave enables
//   locked                 outputs valid and phase aligned
module multi_clken_gen
   import multi_clken_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                                   refclk,
   input  logic                                   rst,
   input  logic                                   cfg_valid,
   output logic                                   cfg_ready,
   input  logic [multi_clken_pkg::ch_width(NUM_CH)-1:0] cfg_ch,
   input  logic [DIV_W-1:0]                       cfg_div,
   input  logic [DIV_W-1:0]                       cfg_phase,
   output logic                                   cfg_err,
   input  logic [NUM_CH-1:0]                      ch_enable,
   output logic [NUM_CH-1:0]                      clken_out,
   output logic [NUM_CH-1:0]                      clksq_out,
   output logic                                   locked
);

   localparam int CH_W = ch_width(NUM_CH);
   localparam int SW   = settle_width(LOCK_CYCLES);

   state_e           state_q, state_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [CH_W-1:0]  req_ch_q, req_ch_d;
   logic [DIV_W-1:0] req_div_q, req_div_d;
   logic [DIV_W-1:0] req_phase_q, req_phase_d;

   logic             hs, apply, bad_ch, clamp;
   logic [DIV_W-1:0] phase_wr;

   assign cfg_ready = (state_q != APPLY);
   assign hs        = cfg_valid & cfg_ready;
   assign apply     = (state_q == APPLY);

   // Request is captured on the handshake so cfg_* may change during APPLY.
   assign bad_ch   = (32'(req_ch_q) >= NUM_CH);
   assign clamp    = (req_div_q != '0) && (req_phase_q >= req_div_q);
   assign phase_wr = clamp ? (req_div_q - DIV_W'(1)) : req_phase_q;

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      locked_d    = locked_q;
      err_d       = 1'b0;
      req_ch_d    = req_ch_q;
      req_div_d   = req_div_q;
      req_phase_d = req_phase_q;
      if (hs) begin
         req_ch_d    = cfg_ch;
         req_div_d   = cfg_div;
         req_phase_d = cfg_phase;
      end
      case (state_q)
         SETTLE: begin
            // A request here abandons the current settle window.
            if (hs) begin
               state_d  = APPLY;
               locked_d = 1'b0;
            end else if (settle_q == '0) begin
               state_d  = LOCKED;
               locked_d = 1'b1;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         LOCKED: begin
            if (hs) begin
               state_d  = APPLY;
               locked_d = 1'b0;
            end
         end
         APPLY: begin
            err_d    = clamp | bad_ch;
            settle_d = SW'(LOCK_CYCLES - 1);
            state_d  = SETTLE;
         end
         default: begin
            state_d  = SETTLE;
            settle_d = SW'(LOCK_CYCLES - 1);
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= SETTLE;
         settle_q    <= SW'(LOCK_CYCLES - 1);
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         req_ch_q    <= '0;
         req_div_q   <= '0;
         req_phase_q <= '0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         req_ch_q    <= req_ch_d;
         req_div_q   <= req_div_d;
         req_phase_q <= req_phase_d;
      end
   end

   assign locked  = locked_q;
   assign cfg_err = err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clken_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .refclk_i (refclk),
         .rst_i    (rst),
         .clr_i    (apply),
         .load_i   (apply & ~bad_ch & (32'(req_ch_q) == g)),
         .div_i    (req_div_q),
         .phase_i  (phase_wr),
         .locked_i (locked_q),
         .en_i     (ch_enable[g]),
         .clken_o  (clken_out[g]),
         .clksq_o  (clksq_out[g])
      );
   end

endmodule

// File: tb/tb_multi_clken_gen.sv
// tb_multi_clken_gen
//   Directed bench for multi_clken_gen with three channels so that an
//   out-of-range channel select is representable. k tracks cycles since the
//   last counter re-alignment, so expected channel counts are k % div.
module tb_multi_clken_gen;

   localparam int NCH = 3;
   localparam int DW  = 8;

   logic           refclk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready, cfg_err, locked;
   logic [1:0]     cfg_ch = '0;
   logic [DW-1:0]  cfg_div = '0, cfg_phase = '0;
   logic [NCH-1:0] ch_enable = '1;
   logic [NCH-1:0] clken_out, clksq_out;

   int n_chk = 0, n_pass = 0, k = 0;

   typedef struct {
      int ch; int div; int ph;   // request
      int err; int eph; int hi;  // expected error, stored phase, clksq high count
   } vec_t;
   vec_t vt[5];

   always #5 refclk = ~refclk;

   multi_clken_gen #(
      .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(2), .LOCK_CYCLES(16)
   ) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
      .ch_enable(ch_enable), .clken_out(clken_out), .clksq_out(clksq_out),
      .locked(locked)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
   endtask

   task automatic step();
      @(posedge refclk); #1; k++;
   endtask

   // Present a request for one edge; returns in the APPLY cycle.
   task automatic hs(input int ch, input int div, input int ph);
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = DW'(div); cfg_phase = DW'(ph);
      step();
      cfg_valid = 1'b0;
      chk("apply_ready_low", cfg_ready, 0);
      chk("apply_locked_low", locked, 0);
   endtask

   // From the APPLY cycle through to locked high again.
   task automatic relock(input int exp_err);
      step(); k = 0;
      chk("cfg_err_pulse", cfg_err, exp_err);
      chk("ready_back", cfg_ready, 1);
      step();
      chk("cfg_err_single", cfg_err, 0);
      repeat (14) step();
      chk("settle_locked_low", locked, 0);
      step();
      chk("relocked", locked, 1);
   endtask

   initial begin
      vt[0] = '{1, 5, 3, 0, 3, 3};
      vt[1] = '{1, 4, 9, 1, 3, 2};   // phase clamped to 3
      vt[2] = '{2, 0, 0, 0, -1, 0};  // channel off
      vt[3] = '{2, 1, 0, 0, 0, 1};   // constantly high
      vt[4] = '{0, 3, 2, 0, 2, 2};

      // Reset state
      #12;
      chk("rst_locked", locked, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_err", cfg_err, 0);
      chk("rst_clken", clken_out, 0);
      chk("rst_clksq", clksq_out, 0);
      @(negedge refclk); rst = 1'b0; k = 0;
      repeat (15) step();
      chk("boot_locked_low", locked, 0);
      step();
      chk("boot_locked_high", locked, 1);
      for (int c = 0; c < 4; c++) begin
         chk("boot_clken", clken_out, (k % 2 == 0) ? 7 : 0);
         chk("boot_clksq", clksq_out, (k % 2 == 0) ? 7 : 0);
         step();
      end

      // Table-driven reconfiguration
      for (int i = 0; i < 5; i++) begin
         hs(vt[i].ch, vt[i].div, vt[i].ph);
         relock(vt[i].err);
         for (int c = 0; c < 12; c++) begin
            chk($sformatf("v%0d_clken", i), int'(clken_out[vt[i].ch]),
                int'(vt[i].div != 0 && (k % (vt[i].div == 0 ? 1 : vt[i].div)) == vt[i].eph));
            chk($sformatf("v%0d_clksq", i), int'(clksq_out[vt[i].ch]),
                int'(vt[i].div != 0 && (k % (vt[i].div == 0 ? 1 : vt[i].div)) < vt[i].hi));
            if (vt[i].ch != 0) begin
               chk($sformatf("v%0d_ch0_clken", i), int'(clken_out[0]), int'(k % 2 == 0));
               chk($sformatf("v%0d_ch0_clksq", i), int'(clksq_out[0]), int'(k % 2 == 0));
            end
            step();
         end
      end
      // Now: ch0 div3 ph2, ch1 div4 ph3, ch2 div1

      // Second request during SETTLE restarts the window
      hs(1, 3, 0);
      repeat (7) step();
      chk("mid_settle_locked", locked, 0);
      hs(1, 5, 3);
      relock(0);
      for (int c = 0; c < 10; c++) begin
         chk("resettle_ch1_clken", int'(clken_out[1]), int'(k % 5 == 3));
         chk("resettle_ch1_clksq", int'(clksq_out[1]), int'(k % 5 < 3));
         step();
      end

      // Invalid channel: error pulse, resync, nothing written
      hs(3, 7, 1);
      relock(1);
      for (int c = 0; c < 10; c++) begin
         chk("badch_ch1_clken", int'(clken_out[1]), int'(k % 5 == 3));
         chk("badch_ch0_clken", int'(clken_out[0]), int'(k % 3 == 2));
         chk("badch_ch2_clken", int'(clken_out[2]), 1);
         step();
      end

      // Live ch_enable gating leaves counters and lock untouched
      for (int c = 0; c < 3 && (k % 3) != 2; c++) step();
      chk("en_ch0_before", int'(clken_out[0]), 1);
      ch_enable[0] = 1'b0; #1;
      chk("en_ch0_gated", int'(clken_out[0]), 0);
      chk("en_locked_kept", locked, 1);
      chk("en_ch2_unaffected", int'(clken_out[2]), 1);
      step();
      chk("en_ch0_sq_gated", int'(clksq_out[0]), 0);
      ch_enable[0] = 1'b1; #1;
      chk("en_ch0_sq_back", int'(clksq_out[0]), int'(k % 3 < 2));
      step(); step();
      chk("en_ch0_cnt_kept", int'(clken_out[0]), int'(k % 3 == 2));

      // Async reset during APPLY discards programming
      hs(1, 5, 3);
      #2 rst = 1'b1; #1;
      chk("arst_ready", cfg_ready, 1);
      chk("arst_locked", locked, 0);
      chk("arst_clken", clken_out, 0);
      chk("arst_clksq", clksq_out, 0);
      step();
      @(negedge refclk); rst = 1'b0; k = 0;
      repeat (15) step();
      chk("rerst_locked_low", locked, 0);
      step();
      chk("rerst_locked_high", locked, 1);
      for (int c = 0; c < 6; c++) begin
         chk("rerst_clken", clken_out, (k % 2 == 0) ? 7 : 0);
         chk("rerst_clksq", clksq_out, (k % 2 == 0) ? 7 : 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_clken_gen.md
Name: multi_clken_gen

Overview:
Parametrised successor to the fixed single-output PLL wrapper. It generates NUM_CH run-time-programmable clock-enable strobes and square-wave enables, all in the refclk domain. Each channel divides refclk by an integer and has a programmable phase offset. A reconfiguration handshake and a PLL-style locked indication let downstream pixel/overlay logic change rates without leaving the refclk domain.

Parameters:
NUM_CH, 4, number of output channels (1..16)
DIV_W, 8, width of the divide and phase fields
DEFAULT_DIV, 2, divide ratio loaded into every channel on reset (1..2^DIV_W-1)
LOCK_CYCLES, 16, settle cycles before locked asserts (>=1)

Ports:
refclk  in  1  sole clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_div  in  DIV_W  new divide ratio; 0 = channel off
cfg_phase  in  DIV_W  cycle within period at which clken fires
cfg_err  out  1  one-cycle pulse: phase was clamped or cfg_ch >= NUM_CH
ch_enable  in  NUM_CH  live per-channel output gate, no resync
clken_out  out  NUM_CH  one-refclk-wide strobe per divided period
clksq_out  out  NUM_CH  ~50% duty enable, high first ceil(div/2) counts
locked  out  1  outputs valid and phase-aligned

Behaviour:
- Interface: one clock, refclk. Reset rst is asynchronous and active-high. rst has priority over every other event.
- Reset state:
  - every div_i = DEFAULT_DIV, phase_i = 0, cnt_i = 0
  - FSM = SETTLE, settle_cnt = LOCK_CYCLES-1
  - locked = 0, cfg_ready = 1, cfg_err = 0, clken_out = 0, clksq_out = 0
- FSM states SETTLE, LOCKED, APPLY:
  - SETTLE: settle_cnt decrements each cycle. At 0 -> LOCKED with locked <= 1, so locked is first high LOCK_CYCLES edges after reset release.
  - LOCKED: holds until a cfg handshake.
  - Handshake in SETTLE or LOCKED -> APPLY, locked <= 0 on the same edge. A request during SETTLE restarts settling.
  - APPLY lasts one cycle, cfg_ready = 0:
    - writes div/phase of cfg_ch
    - clears all channels' cnt to 0 simultaneously, re-aligning every channel
    - loads settle_cnt = LOCK_CYCLES-1
    - -> SETTLE
- Latency: handshake at edge T; locked low from T+1; cnt = 0 at T+2; locked high again at T+2+LOCK_CYCLES.
- cfg_ready = (state != APPLY). cfg_valid held during APPLY is not consumed until ready returns.
- Channel counter:
  - div >= 1: cnt counts 0..div-1 and wraps to 0.
  - div = 0: cnt held at 0, outputs forced 0.
  - Counters run during SETTLE, so they are aligned when locked rises.
- Outputs are combinational decodes of registered state only:
  - clken_out[i] = locked & ch_enable[i] & (div_i != 0) & (cnt_i == phase_i)
  - clksq_out[i] = locked & ch_enable[i] & (div_i != 0) & (cnt_i < (div_i+1)>>1)
  - div = 1 gives clken and clksq constantly high.
- Phase clamp: if cfg_phase >= cfg_div and cfg_div != 0, store phase = cfg_div-1 and pulse cfg_err on the APPLY edge.
- Invalid channel: if cfg_ch >= NUM_CH, write nothing and pulse cfg_err. The FSM still performs APPLY/SETTLE (resync).
- ch_enable changes take effect the same cycle and never disturb counters or locked.
- rst asserted mid-APPLY or mid-SETTLE returns all channels to DEFAULT_DIV, discarding programmed values.

Decomposition:
- Package multi_clken_pkg contains:
  - FSM state enum (SETTLE, LOCKED, APPLY)
  - CH_W = max(1, $clog2(NUM_CH)) helper function
  - settle counter width function $clog2(LOCK_CYCLES+1)
- Sub-module clken_ch, instantiated NUM_CH times via generate, contains:
  - div/phase registers with load strobe
  - sync-clear, wrap counter
  - clken/clksq decode
- The top holds the FSM, cfg handshake and clamp logic.

Test Plan:
- Reset release, defaults (DEFAULT_DIV=2, LOCK_CYCLES=16, ch_enable=all 1) -> locked 0 for 16 edges then 1. clken_out pulses every 2nd cycle on all channels in phase. clksq_out alternates 1,0.
- Program ch1 div=5 phase=3 at edge T -> cfg_ready 0 at T+1. locked 0 from T+1 to T+17, 1 at T+18. ch1 clken at cnt 3, every 5 cycles. ch1 clksq high 3 of 5 cycles. ch0 still div 2, aligned to the same cnt=0 edge.
- cfg div=4 phase=9 -> cfg_err single pulse, stored phase=3, clken fires at cnt 3.
- cfg div=0 on ch2 -> ch2 outputs stay 0 after lock. Reprogram div=1 -> ch2 clken and clksq constantly 1 once locked.
- Second cfg_valid during SETTLE (8 cycles after the first) -> settle restarts, locked rises LOCK_CYCLES+2 edges after the second handshake. cfg_ch=NUM_CH -> cfg_err, no register change.
- Toggle ch_enable[0] while locked -> ch0 outputs gated immediately, cnt unaffected. Assert rst mid-SETTLE -> all outputs 0 asynchronously and divides revert to 2.
